fd_hazard_ctrl: RTL and testbench

- Control-side counterpart of the fetch/decode pipeline register; it generates that register's write-enable and flush, and the PC write-enable.
- Inspects the instruction held in decode and the load in execute, and resolves three conditions: load-use stalls, taken-branch flushes, and HLT freeze.
- Inserts bubbles into the decode/execute register.
- Keeps saturating stall and flush counters for performance debug.

---
 rtl/fd_hazard_ctrl.sv | 77 +++++++
 tb/tb_fd_hazard_ctrl.sv | 120 ++++++++++++
 2 files changed

// File: rtl/fd_hazard_ctrl.sv
// fd_hazard_ctrl: F/D register and PC enables from load-use stall, taken-branch flush and HLT freeze, with saturating counters
module fd_hazard_ctrl #(
  parameter logic [3:0] OP_LW  = 4'b1000,
  parameter logic [3:0] OP_SW  = 4'b1001,
  parameter logic [3:0] OP_BR  = 4'b1101,
  parameter logic [3:0] OP_HLT = 4'b1111,
  parameter int         CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      instr_fd,
  input  logic             dx_mem_read,
  input  logic [3:0]       dx_rd,
  input  logic             branch_taken_d,
  output logic             pc_write,
  output logic             fd_write,
  output logic             fd_flush,
  output logic             dx_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);
  typedef enum logic [1:0] {RUN, LU_STALL, HALT} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
  logic [3:0] op;
  logic s1v, s2v, hz;
  always_comb begin
    op = instr_fd[15:12];
    s1v = op != OP_HLT;
    s2v = !(op == OP_LW || op == OP_BR || (op[3] && op != OP_SW));
    hz = state_q == RUN && dx_mem_read && dx_rd != 4'h0 &&
         ((s1v && dx_rd == instr_fd[7:4]) ||
          (s2v && dx_rd == (op[3] ? instr_fd[11:8] : instr_fd[3:0])));
  end
  always_comb begin
    pc_write = 1'b1;
    fd_write = 1'b1;
    fd_flush = 1'b0;
    dx_bubble = 1'b0;
    halted = 1'b0;
    state_d = RUN;
    if (rst) begin
      pc_write = 1'b0;
      fd_write = 1'b0;
      fd_flush = 1'b1;
      dx_bubble = 1'b1;
    end else if (state_q == HALT) begin
      pc_write = 1'b0;
      fd_write = 1'b0;
      dx_bubble = 1'b1;
      halted = 1'b1;
      state_d = HALT;
    end else if (hz) begin
      pc_write = 1'b0;
      fd_write = 1'b0;
      dx_bubble = 1'b1;
      state_d = LU_STALL;
    end else if (op == OP_HLT) begin
      pc_write = 1'b0;
      fd_write = 1'b0;
      state_d = HALT;
    end else if (branch_taken_d) begin
      fd_flush = 1'b1;
    end
    stall_d = rst ? '0 : stall_q + CNT_W'(hz && !(&stall_q));
    flush_d = rst ? '0 : flush_q + CNT_W'(fd_flush && !(&flush_q));
  end
  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else state_q <= state_d;
    stall_q <= stall_d;
    flush_q <= flush_d;
  end
  assign stall_cycles = stall_q;
  assign flush_count = flush_q;
endmodule

// File: tb/tb_fd_hazard_ctrl.sv
// tb_fd_hazard_ctrl: randomized and directed check of fd_hazard_ctrl against a behavioural model
module tb_fd_hazard_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, mr, br;
  logic [15:0] instr;
  logic [3:0] rd;
  logic pw, fw, fl, bub, hal, pw4, fw4, fl4, bub4, hal4;
  logic [15:0] sc, fc;
  logic [3:0] sc4, fc4;
  int errs = 0, checks = 0;
  bit m_halt, m_stall, m_known;
  int m_sc, m_fc;
  fd_hazard_ctrl u16 (.clk(clk), .rst(rst), .instr_fd(instr), .dx_mem_read(mr), .dx_rd(rd),
    .branch_taken_d(br), .pc_write(pw), .fd_write(fw), .fd_flush(fl), .dx_bubble(bub),
    .halted(hal), .stall_cycles(sc), .flush_count(fc));
  fd_hazard_ctrl #(.CNT_W(4)) u4 (.clk(clk), .rst(rst), .instr_fd(instr), .dx_mem_read(mr), .dx_rd(rd),
    .branch_taken_d(br), .pc_write(pw4), .fd_write(fw4), .fd_flush(fl4), .dx_bubble(bub4),
    .halted(hal4), .stall_cycles(sc4), .flush_count(fc4));
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  function automatic bit reads(input logic [15:0] i, input logic [3:0] r);
    logic [3:0] op;
    op = i[15:12];
    if (op == 4'hF) return 1'b0;
    if (r == i[7:4]) return 1'b1;
    if (!op[3]) return r == i[3:0];
    if (op == 4'h9) return r == i[11:8];
    return 1'b0;
  endfunction
  task automatic step(input bit r, input logic [15:0] i, input bit m, input logic [3:0] d, input bit b);
    bit hz;
    logic [4:0] e;
    @(posedge clk);
    #1;
    rst = r; instr = i; mr = m; rd = d; br = b;
    #4;
    hz = !r && !m_halt && !m_stall && m && d != 0 && reads(i, d);
    if (r) e = 5'b00110;
    else if (m_halt) e = 5'b00011;
    else if (hz) e = 5'b00010;
    else if (i[15:12] == 4'hF) e = 5'b00000;
    else if (b) e = 5'b11100;
    else e = 5'b11000;
    chk("pc_write", pw, e[4]);
    chk("fd_write", fw, e[3]);
    chk("fd_flush", fl, e[2]);
    chk("dx_bubble", bub, e[1]);
    chk("halted", hal, e[0]);
    chk("flags_w4", {pw4, fw4, fl4, bub4, hal4}, e);
    if (m_known) begin
      chk("stall_cycles", sc, m_sc > 65535 ? 65535 : m_sc);
      chk("flush_count", fc, m_fc > 65535 ? 65535 : m_fc);
      chk("stall_cycles_w4", sc4, m_sc > 15 ? 15 : m_sc);
      chk("flush_count_w4", fc4, m_fc > 15 ? 15 : m_fc);
    end
    if (r) begin
      m_halt = 0; m_stall = 0; m_sc = 0; m_fc = 0; m_known = 1;
    end else begin
      if (!m_halt) m_halt = !hz && i[15:12] == 4'hF;
      m_stall = hz;
      m_sc += int'(hz);
      m_fc += int'(e[2]);
    end
  endtask
  initial begin
    step(1, 16'h1234, 1, 4'h3, 1);
    chk("rst_flush", fl, 1);
    step(1, 16'hF000, 0, 4'h0, 0);
    chk("rst_bubble", bub, 1);
    step(0, 16'h0123, 0, 4'h0, 0);
    chk("run_pc", pw, 1);
    chk("rst_cnt", sc, 0);
    step(0, 16'h0132, 1, 4'h3, 0);
    chk("lu_bubble", bub, 1);
    step(0, 16'h0132, 1, 4'h3, 0);
    chk("lu_once", pw, 1);
    step(0, 16'h0123, 0, 4'h0, 0);
    chk("lu_count", sc, 1);
    step(0, 16'h0100, 1, 4'h0, 0);
    chk("r0_nostall", pw, 1);
    step(0, 16'h8315, 1, 4'h5, 0);
    chk("lw_nostall", pw, 1);
    step(0, 16'h9540, 1, 4'h5, 0);
    chk("sw_stall", bub, 1);
    step(0, 16'h0123, 0, 4'h0, 1);
    chk("br_flush", fl, 1);
    step(0, 16'h0123, 0, 4'h0, 0);
    chk("br_count", fc, 1);
    chk("sw_count", sc, 2);
    step(0, 16'h0132, 1, 4'h3, 1);
    chk("hz_over_br", fl, 0);
    step(0, 16'h0132, 1, 4'h3, 1);
    step(0, 16'hF000, 0, 4'h0, 1);
    chk("hlt_decode_bub", bub, 0);
    step(0, 16'h0123, 0, 4'h0, 1);
    chk("halted", hal, 1);
    chk("halt_noflush", fl, 0);
    step(1, 16'h0123, 0, 4'h0, 0);
    step(0, 16'h0123, 0, 4'h0, 0);
    chk("halt_exit", hal, 0);
    for (int k = 0; k < 20; k++) step(0, 16'h0123, 0, 4'h0, 1);
    step(0, 16'h0123, 0, 4'h0, 0);
    chk("sat_w4", fc4, 4'hF);
    for (int k = 0; k < 3000; k++) begin
      logic [15:0] i;
      logic [3:0] d;
      i = {($urandom_range(0, 19) == 0) ? 4'hF : 4'($urandom_range(0, 14)), 12'($urandom)};
      d = $urandom_range(0, 1) ? i[7:4] : ($urandom_range(0, 1) ? i[11:8] : 4'($urandom));
      step($urandom_range(0, 59) == 0, i, 1'($urandom), d, $urandom_range(0, 3) == 0);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
